// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: config byte layout,
// sequencer state encoding, data widths and a config sanitising helper.
package spi_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Config byte layout: {mode, len, cpol, cpha, div[2:0], rsvd}
    localparam int CFG_MODE   = 7;
    localparam int CFG_LEN    = 6;
    localparam int CFG_CPOL   = 5;
    localparam int CFG_CPHA   = 4;
    localparam int CFG_DIV_HI = 3;
    localparam int CFG_DIV_LO = 1;
    localparam int CFG_RSVD   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // The sequencer always drives the engine as leader and never passes the
    // reserved bit through, whatever the requester supplied.
    function automatic logic [BYTE_W-1:0] leader_cfg(input logic [BYTE_W-1:0] cfg);
        logic [BYTE_W-1:0] c;
        c           = cfg;
        c[CFG_MODE] = 1'b1;
        c[CFG_RSVD] = 1'b0;
        return c;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_txn_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr with
// wrap-around and returns the first set bit as one-hot grant plus index.
// The pointer register itself belongs to the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    function automatic int slot(input logic [IW-1:0] base, input int k);
        return (int'(base) + k) % N;
    endfunction

    // First requester at or after the pointer, wrapping past N-1 to 0.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[slot(ptr, k)]) begin
                valid               = 1'b1;
                idx                 = IW'(slot(ptr, k));
                gnt[slot(ptr, k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Multi-requester front end for a single SPI leader engine. Arbitrates
// round-robin, frames each transfer with its chip select (setup, hold and
// inter-transaction gap), starts the engine, supervises completion with an
// optional timeout and hands the RX word back to the granted requester.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [BYTE_W*N_REQ-1:0]   req_cfg,
    input  logic [WORD_W*N_REQ-1:0]   req_txd,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [WORD_W-1:0]         rxd,
    output logic                      err,
    output logic                      busy,
    output logic [N_REQ-1:0]          cs_n,
    output logic [BYTE_W-1:0]         eng_cfg,
    output logic [WORD_W-1:0]         eng_txd,
    output logic                      eng_start,
    output logic                      eng_abort,
    input  logic                      eng_done,
    input  logic [WORD_W-1:0]         eng_rxd
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] SETUP = ST_SETUP;
    localparam logic [2:0] XFER  = ST_XFER;
    localparam logic [2:0] HOLD  = ST_HOLD;
    localparam logic [2:0] GAP   = ST_GAP;

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int MAX_CYC = max4(SETUP_CYC, HOLD_CYC, GAP_CYC, TIMEOUT);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] XFER_LOAD  = CNT_W'(TIMEOUT);

    logic [2:0]         state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [N_REQ-1:0]   gnt_q,       gnt_d;
    logic [N_REQ-1:0]   done_q,      done_d;
    logic [WORD_W-1:0]  rxd_q,       rxd_d;
    logic               err_q,       err_d;
    logic               busy_q,      busy_d;
    logic [N_REQ-1:0]   cs_n_q,      cs_n_d;
    logic [BYTE_W-1:0]  eng_cfg_q,   eng_cfg_d;
    logic [WORD_W-1:0]  eng_txd_q,   eng_txd_d;
    logic               eng_start_q, eng_start_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [BYTE_W-1:0]  cfg_arr [N_REQ];
    logic [WORD_W-1:0]  txd_arr [N_REQ];
    logic [N_REQ-1:0]   idx_q_onehot;
    logic [N_REQ-1:0]   idx_d_onehot;
    logic [CNT_W-1:0]   cnt_dec;
    logic               timeout_hit;
    logic               cs_active_d;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Unpack the flat requester buses and decode the current/next owner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign cfg_arr[gi]      = req_cfg[gi*BYTE_W +: BYTE_W];
            assign txd_arr[gi]      = req_txd[gi*WORD_W +: WORD_W];
            assign idx_q_onehot[gi] = (idx_q == IDX_W'(gi));
            assign idx_d_onehot[gi] = (idx_d == IDX_W'(gi));
        end
    endgenerate

    // Shared counter only ever counts down and sticks at zero.
    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    // Timeout fires on the cycle the XFER timer runs out; a coincident
    // eng_done takes precedence, so the abort is suppressed in that case.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == XFER) &&
                         (cnt_q == '0) && !eng_done;

    // Next-state and datapath decisions for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_dec;
        gnt_d       = '0;
        done_d      = '0;
        rxd_d       = rxd_q;
        err_d       = err_q;
        eng_cfg_d   = eng_cfg_q;
        eng_txd_d   = eng_txd_q;
        eng_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d     = arb_gnt;
                    idx_d     = arb_idx;
                    eng_cfg_d = leader_cfg(cfg_arr[arb_idx]);
                    eng_txd_d = txd_arr[arb_idx];
                    ptr_d     = (arb_idx == IDX_W'(N_REQ - 1)) ? '0
                                                               : arb_idx + IDX_W'(1);
                    cnt_d     = SETUP_LOAD;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    eng_start_d = 1'b1;
                    cnt_d       = XFER_LOAD;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (eng_done) begin
                    rxd_d   = eng_cfg_q[CFG_LEN] ? eng_rxd
                                                 : {{(WORD_W-BYTE_W){1'b0}}, eng_rxd[BYTE_W-1:0]};
                    err_d   = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else if (timeout_hit) begin
                    rxd_d   = '0;
                    err_d   = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = idx_q_onehot;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Chip select and busy are registered from the next state so they line
    // up exactly with the state they describe.
    always_comb begin
        cs_active_d = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
        cs_n_d      = cs_active_d ? ~idx_d_onehot : '1;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset releases every chip select at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rxd_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= '1;
            eng_cfg_q   <= '0;
            eng_txd_q   <= '0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rxd_q       <= rxd_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
            eng_cfg_q   <= eng_cfg_d;
            eng_txd_q   <= eng_txd_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rxd       = rxd_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign cs_n      = cs_n_q;
    assign eng_cfg   = eng_cfg_q;
    assign eng_txd   = eng_txd_q;
    assign eng_start = eng_start_q;
    assign eng_abort = timeout_hit;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed plus randomized bench for spi_txn_sequencer. A transaction-level
// model (pointer-based round robin, timing totals from the setup/hold/gap
// rules, RX masking and timeout rules) predicts each transaction; an engine
// stand-in answers eng_start after a chosen latency, or never.
module tb_spi_txn_sequencer;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int H  = 2;
    localparam int G  = 4;
    localparam int TO = 31;   // long enough for the 20-cycle engine case

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_cfg;
    logic [16*N-1:0] req_txd;
    logic [N-1:0]    gnt, done, cs_n;
    logic [15:0]     rxd, eng_txd, eng_rxd;
    logic            err, busy, eng_start, eng_abort, eng_done;
    logic [7:0]      eng_cfg;

    int checks    = 0;
    int errors    = 0;
    int ptr_m     = 0;
    int high_run  = 0;

    always #5 clk = ~clk;

    spi_txn_sequencer #(
        .N_REQ(N), .SETUP_CYC(S), .HOLD_CYC(H), .GAP_CYC(G), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_cfg(req_cfg), .req_txd(req_txd),
        .gnt(gnt), .done(done), .rxd(rxd), .err(err), .busy(busy), .cs_n(cs_n),
        .eng_cfg(eng_cfg), .eng_txd(eng_txd), .eng_start(eng_start),
        .eng_abort(eng_abort), .eng_done(eng_done), .eng_rxd(eng_rxd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin reference: first requester at or after the pointer.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return 0;
    endfunction

    // One full transaction: lat<0 means the engine never answers.
    task automatic run_txn(input int lat, input logic [15:0] rx, input bit drop,
                           input string tag, output int gap_seen);
        int exp_idx, xfer_len, total, cs_low, cs_bad, starts, start_c, aborts, abort_rel, done_c;
        bit got, timed;
        logic [7:0]  cfg_i, exp_cfg, cfg_at_start;
        logic [15:0] exp_txd, exp_rxd, txd_at_start;
        exp_idx  = model_pick(req);
        cfg_i    = req_cfg[8*exp_idx +: 8];
        exp_txd  = req_txd[16*exp_idx +: 16];
        exp_cfg  = {1'b1, cfg_i[6:1], 1'b0};
        timed    = (lat < 0) || (lat > TO);
        xfer_len = timed ? TO + 1 : lat + 1;
        total    = S + xfer_len + H;
        exp_rxd  = timed ? 16'h0000 : (cfg_i[6] ? rx : {8'h00, rx[7:0]});
        got = 0; cs_low = 0; cs_bad = 0; starts = 0; start_c = -1;
        aborts = 0; abort_rel = -1; done_c = -1;
        cfg_at_start = '0; txd_at_start = '0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(posedge clk); #1 eng_done = 1'b0;
            @(negedge clk);
            if (gnt != '0) got = 1;
            else if (cs_n === '1) high_run++;
        end
        gap_seen = high_run;
        chk({tag, "_gnt"}, 32'(gnt), 32'(onehot(exp_idx)));
        if (!got) return;
        ptr_m = (exp_idx + 1) % N;
        if (drop) req[exp_idx] = 1'b0;
        if (cs_n !== '1) begin
            cs_low++;
            if (cs_n !== ~onehot(exp_idx)) cs_bad++;
        end
        for (int c = 1; c < 400 && done_c < 0; c++) begin
            @(posedge clk);
            #1 eng_done = (start_c >= 0) && (lat >= 0) && (c - start_c == lat);
            eng_rxd  = eng_done ? rx : 16'($urandom);
            @(negedge clk);
            if (eng_start) begin
                starts++; start_c = c; cfg_at_start = eng_cfg; txd_at_start = eng_txd;
            end
            if (eng_abort) begin aborts++; abort_rel = c - start_c; end
            if (cs_n !== '1) begin
                cs_low++;
                if (cs_n !== ~onehot(exp_idx)) cs_bad++;
            end
            if (done != '0) done_c = c;
        end
        eng_done = 1'b0;
        high_run = 1;
        chk({tag, "_starts"},   32'(starts), 32'd1);
        chk({tag, "_start_at"}, 32'(start_c), 32'(S));
        chk({tag, "_eng_cfg"},  32'(cfg_at_start), 32'(exp_cfg));
        chk({tag, "_eng_txd"},  32'(txd_at_start), 32'(exp_txd));
        chk({tag, "_g2d"},      32'(done_c), 32'(total));
        chk({tag, "_cs_low"},   32'(cs_low), 32'(total));
        chk({tag, "_cs_bad"},   32'(cs_bad), 32'd0);
        chk({tag, "_aborts"},   32'(aborts), timed ? 32'd1 : 32'd0);
        if (timed) chk({tag, "_abort_at"}, 32'(abort_rel), 32'(TO));
        chk({tag, "_done"},     32'(done), 32'(onehot(exp_idx)));
        chk({tag, "_rxd"},      32'(rxd), 32'(exp_rxd));
        chk({tag, "_err"},      32'(err), 32'(timed));
        chk({tag, "_busy"},     32'(busy), 32'd1);
        $display("txn %s: req%0d lat=%0d cfg=%h rxd=%h err=%0d grant->done=%0d",
                 tag, exp_idx, lat, cfg_at_start, rxd, err, done_c);
    endtask

    initial begin
        int gap;
        bit got;
        rst = 1'b1; req = '0; req_cfg = '0; req_txd = '0;
        eng_done = 1'b0; eng_rxd = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rxd", 32'(rxd), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_eng_cfg", 32'(eng_cfg), 32'd0);
        chk("rst_eng_txd", 32'(eng_txd), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_eng_abort", 32'(eng_abort), 32'd0);
        rst = 1'b0;

        // Single request
        req_cfg[15:8] = 8'hA6; req_txd[31:16] = 16'h00C3; req = 4'b0010;
        run_txn(20, 16'h005A, 1, "single", gap);

        // Round robin with all requests held
        for (int i = 0; i < N; i++) begin
            req_cfg[8*i +: 8]   = 8'hC0 | 8'(i << 1);
            req_txd[16*i +: 16] = 16'h1000 + 16'(i);
        end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            run_txn(6 + t, 16'hA500 + 16'(t), 0, "rr", gap);
            if (t > 0) chk("rr_gap", 32'(gap >= G), 32'd1);
        end
        req = '0;

        // len=0 masking, then len=1 pass-through
        req_cfg[31:24] = 8'h86; req_txd[63:48] = 16'h1234; req = 4'b1000;
        run_txn(5, 16'hBEEF, 1, "len0", gap);
        req_cfg[31:24] = 8'hC6; req = 4'b1000;
        run_txn(5, 16'hBEEF, 1, "len1", gap);

        // Timeout, then a normal transaction
        req_cfg[7:0] = 8'hE7; req_txd[15:0] = 16'h5555; req = 4'b0001;
        run_txn(-1, 16'h0000, 1, "timeout", gap);
        req = 4'b0100;
        run_txn(3, 16'h7E7E, 1, "after_to", gap);

        // eng_done lands on the cycle the timer expires
        req = 4'b0010;
        run_txn(TO, 16'h3C3C, 1, "collide", gap);

        // Randomized traffic
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                req_cfg[8*i +: 8]   = 8'($urandom);
                req_txd[16*i +: 16] = 16'($urandom);
            end
            req = 4'($urandom_range(1, 15));
            run_txn(int'($urandom_range(1, TO + 4)), 16'($urandom), 1, "rand", gap);
        end
        req = '0;

        // Reset in the middle of XFER
        req = 4'b0100; got = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (gnt != '0) got = 1;
        end
        chk("mid_gnt", 32'(gnt), 32'(onehot(model_pick(req))));
        req = '0;
        repeat (S + 3) @(negedge clk);
        chk("mid_cs_low", 32'(cs_n), 32'b1011);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n), 32'hF);
        chk("mid_rst_abort", 32'(eng_abort), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_done", 32'(done), 32'd0);
            chk("mid_rst_abort_hold", 32'(eng_abort), 32'd0);
        end
        rst = 1'b0;
        ptr_m = 0;
        $display("txn reset: rst asserted during XFER, cs_n=%b", cs_n);
        req = 4'b1001; req_cfg[7:0] = 8'h46;
        run_txn(4, 16'h0F0F, 1, "post_rst", gap);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
